// File: rtl/ahb_slave_mem_responder.sv
// AHB-Lite slave backed by a word-addressed memory, with optional data-phase
// wait states and a two-cycle ERROR response for out-of-range or illegal transfers.
module ahb_slave_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic                  hready,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [3:0]            hwstrb,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hexokay
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  logic [1:0]            state;
  logic [1:0]            cnt;
  logic                  pend;
  logic                  lat_write;
  logic [IDX_W-1:0]      lat_idx;
  logic [2:0]            lat_size;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-3:0] word;
  logic [IDX_W-1:0]      s_idx;
  logic                  misaligned;
  logic                  err;
  logic                  sample;
  logic                  complete;
  logic                  commit_wr;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  unused_bits;

  assign word  = haddr[ADDR_WIDTH-1:2];
  assign s_idx = haddr[IDX_W+1:2];

  assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign err = (word >= (ADDR_WIDTH-2)'(MEM_DEPTH)) || (hsize > 3'd2) || misaligned;

  assign hreadyout = (state == S_IDLE) || (state == S_ERR2);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign hrdata    = rdata_q;
  assign hexokay   = 1'b0;

  assign sample    = hselx && hready && htrans[1] && hreadyout;
  assign complete  = (state == S_IDLE) && pend;
  assign commit_wr = complete && lat_write && !hreset;

  // Byte-lane merge of the pending write; also forwarded to a read sampled on the commit edge.
  always_comb begin
    merged = mem[lat_idx];
    for (int i = 0; i < 4; i++) begin
      if (hwstrb[i]) merged[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  assign fwd_data = (commit_wr && (lat_idx == s_idx)) ? merged : mem[s_idx];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      pend      <= 1'b0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_size  <= 3'd0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 2'd0) begin
            state <= S_IDLE;
            if (!lat_write) rdata_q <= mem[lat_idx];
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_ERR1: state <= S_ERR2;
        default: begin
          if (complete) pend <= 1'b0;
          if (state == S_ERR2) state <= S_IDLE;
          // A new address phase may overlap the completing data phase.
          if (sample) begin
            lat_write <= hwrite;
            lat_size  <= hsize;
            lat_idx   <= s_idx;
            if (err) begin
              state <= S_ERR1;
              pend  <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
              pend  <= 1'b1;
            end else begin
              state <= S_IDLE;
              pend  <= 1'b1;
              if (!hwrite) rdata_q <= fwd_data;
            end
          end
        end
      endcase
    end
  end

  // Memory has no reset so contents survive a bus reset.
  always_ff @(posedge hclk) begin
    if (commit_wr) mem[lat_idx] <= merged;
  end

  assign unused_bits = ^{hburst, htrans[0], lat_size};

endmodule

// File: doc/ahb_slave_mem_responder.md
AHB_SLAVE_MEM_RESPONDER -- requirements
Module: ahb_slave_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit memory words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, data-phase wait cycles; legal range 0..3.
REQ-005 SHALL have port hclk, input, 1, clock; all logic is on the rising edge.
REQ-006 SHALL have port hreset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port hselx, input, 1, slave select.
REQ-008 SHALL have port hready, input, 1, bus-level ready, which qualifies the address phase.
REQ-009 SHALL have port haddr, input, ADDR_WIDTH, transfer address.
REQ-010 SHALL have port htrans, input, 2, transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 SHALL have port hwrite, input, 1, 1 for write.
REQ-012 SHALL have port hsize, input, 3, transfer size.
REQ-013 SHALL have port hburst, input, 3, burst type; it is accepted and ignored.
REQ-014 SHALL have port hwdata, input, DATA_WIDTH, write data, valid in the data phase.
REQ-015 SHALL have port hwstrb, input, 4, byte-lane enables, valid in the data phase.
REQ-016 SHALL have port hreadyout, output, 1, slave ready.
REQ-017 SHALL have port hresp, output, 1, 0=OKAY, 1=ERROR.
REQ-018 SHALL have port hrdata, output, DATA_WIDTH, read data.
REQ-019 SHALL have port hexokay, output, 1, exclusive-okay; it is tied to 0.

Function
REQ-020 SHALL sample an address phase on an edge where hselx & hready & htrans[1] are all 1, latching haddr, hwrite and hsize.
REQ-021 SHALL treat a selected IDLE or BUSY transfer as a zero-wait OKAY with no memory access.
REQ-022 SHALL classify a sampled transfer as erroneous if any of these hold:
- haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH;
- hsize > 2;
- haddr is misaligned for hsize (hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0).
REQ-023 SHALL implement states IDLE, WAIT, ERR1 and ERR2, with IDLE as the completion/ready state.
REQ-024 SHALL transition as follows on a valid sample:
- error -> ERR1;
- else WAIT_STATES>0 -> WAIT, with the counter loaded to WAIT_STATES-1;
- else stay in IDLE and complete in the next cycle.
REQ-025 In WAIT, SHALL drive hreadyout=0 and hresp=0, decrement the counter each cycle, and move to IDLE once the counter is 0.
REQ-026 SHALL complete the data phase in the first cycle of IDLE following a sample, with hreadyout=1 and hresp=0.
REQ-027 SHALL produce the error response as two cycles:
- ERR1: hreadyout=0, hresp=1;
- ERR2: hreadyout=1, hresp=1;
- then IDLE.
REQ-028 SHALL never access memory for an erroneous transfer.
REQ-029 Latency: a non-error transfer SHALL complete WAIT_STATES+1 cycles after its address-sample edge.
REQ-030 For a write, SHALL commit hwdata byte lane i to the latched word on the completing edge, only where hwstrb[i]=1.
REQ-031 For a read, SHALL hold hrdata = mem[latched word index] during the completing cycle.
REQ-032 SHALL hold hrdata at its previous value in all other cycles.
REQ-033 Pipelining: SHALL sample a new address phase on the same edge that completes the prior data phase; back-to-back zero-wait transfers sustain one transfer per cycle.
REQ-034 Read-after-write hazard: when a read address is sampled on the same edge as a write commit to the same word, the read SHALL return the post-write merged data.
REQ-035 SHALL not sample an address phase while hreadyout=0; hready is then low at bus level.
REQ-036 SHALL keep hreadyout=1 and hresp=0 in IDLE whenever no data phase is pending.

Reset
REQ-037 With hreset=1 at a rising edge, SHALL set state=IDLE, counter=0, hreadyout=1, hresp=0, hrdata=0 and hexokay=0.
REQ-038 SHALL discard a pending write on reset during WAIT/ERR1/ERR2, and return to IDLE with hreadyout=1 after that edge.
REQ-039 SHALL not reset memory contents.

Verification
REQ-040 Reset, then idle bus -> hreadyout=1, hresp=0, hrdata=0 held.
REQ-041 WAIT_STATES=0: NONSEQ write 0x10 with 0xDEADBEEF and hwstrb=0xF, then NONSEQ read 0x10 back-to-back -> the read completes the cycle after its address phase with hrdata=0xDEADBEEF (forwarding case).
REQ-042 WAIT_STATES=2: read 0x10 -> hreadyout low for 2 cycles, then high with hrdata=0xDEADBEEF and hresp=0.
REQ-043 Write 0x10 with 0x11223344 and hwstrb=0x5 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-044 Read from 0x400 (MEM_DEPTH=256), and separately hsize=2 at 0x12 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then OKAY idle; memory unchanged.
REQ-045 WAIT_STATES=3: assert hreset in the second wait cycle of a write to 0x20 -> hreadyout=1 the next cycle, and a later read of 0x20 returns the old value.
